// File: rtl/button_logic_pkg.sv
// Shared constants for the push-button logic block: reduction mode encodings.
// Combinational definitions only; no latency and no backpressure.
package button_logic_pkg;

  localparam logic [1:0] MODE_AND = 2'b00;
  localparam logic [1:0] MODE_OR  = 2'b01;
  localparam logic [1:0] MODE_XOR = 2'b10;
  localparam logic [1:0] MODE_MAJ = 2'b11;

endpackage

// File: rtl/debounce_ch.sv
// One button channel: 2-flop synchroniser, stability counter and debounced level flop.
// Latency raw -> level is 2 + DEBOUNCE_CYCLES cycles; no backpressure.
module debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  logic             sync_q1;
  logic             sync_q2;
  logic             db;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  // The counter only runs while the synchronised input disagrees with the accepted
  // level, so any agreement (end of a glitch) restarts the stability window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db  <= 1'b0;
      cnt <= '0;
    end else if (sync_q2 == db) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      db  <= sync_q2;
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign level = db;

endmodule

// File: rtl/button_logic_debounced.sv
// Debounced push buttons with a mode-selected reduction, LED mirrors and a change strobe.
// Latency btn_in -> led 2+DEBOUNCE_CYCLES, led -> result/result_chg +1; no backpressure.
module button_logic_debounced
  import button_logic_pkg::*;
#(
  parameter int N_IN            = 2,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] btn_in,
  input  logic [1:0]      mode,
  output logic            enable,
  output logic [N_IN-1:0] led,
  output logic            result,
  output logic            result_chg
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PC_W  = $clog2(N_IN + 1);

  logic [N_IN-1:0] db;
  logic [PC_W-1:0] pc;
  logic            result_nxt;

  for (genvar i = 0; i < N_IN; i++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn_in[i]),
      .level(db[i])
    );
  end

  assign led = db;

  always_comb begin
    pc = '0;
    for (int i = 0; i < N_IN; i++) begin
      pc = pc + PC_W'(db[i]);
    end
    case (mode)
      MODE_AND: result_nxt = &db;
      MODE_OR:  result_nxt = |db;
      MODE_XOR: result_nxt = ^db;
      default:  result_nxt = (pc > PC_W'(N_IN / 2));
    endcase
  end

  // Mode and level changes land in the same comparison, so one edge yields at most one pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable     <= 1'b0;
      result     <= 1'b0;
      result_chg <= 1'b0;
    end else begin
      enable     <= 1'b1;
      result     <= result_nxt;
      result_chg <= (result_nxt != result);
    end
  end

endmodule

// File: tb/tb_button_logic_debounced.sv
// Directed bench for button_logic_debounced with N_IN=3, DEBOUNCE_CYCLES=4.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_button_logic_debounced;

  logic       clk;
  logic       rst;
  logic [2:0] btn_in;
  logic [1:0] mode;
  logic       enable;
  logic [2:0] led;
  logic       result;
  logic       result_chg;

  int n_checks;
  int n_errors;

  typedef struct {
    logic [2:0] btn;
    logic [1:0] mode;
    int         cycles;
    logic [2:0] led;
    logic       res;
    logic       chg;
  } vec_t;

  vec_t vecs [25];

  button_logic_debounced #(
    .N_IN           (3),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .mode      (mode),
    .enable    (enable),
    .led       (led),
    .result    (result),
    .result_chg(result_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic en, input logic [2:0] l,
                           input logic r, input logic c);
    check({name, ".enable"}, {7'd0, enable}, {7'd0, en});
    check({name, ".led"}, {5'd0, led}, {5'd0, l});
    check({name, ".result"}, {7'd0, result}, {7'd0, r});
    check({name, ".result_chg"}, {7'd0, result_chg}, {7'd0, c});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    //          btn     mode   cyc  led     res   chg
    // Drive all channels back to 0 from 111 (AND mode)
    vecs[0]  = '{3'b000, 2'b00, 5, 3'b111, 1'b1, 1'b0};
    vecs[1]  = '{3'b000, 2'b00, 1, 3'b000, 1'b1, 1'b0};
    vecs[2]  = '{3'b000, 2'b00, 1, 3'b000, 1'b0, 1'b1};
    vecs[3]  = '{3'b000, 2'b00, 1, 3'b000, 1'b0, 1'b0};
    // 3-cycle glitch on btn_in[0] in OR mode is rejected
    vecs[4]  = '{3'b001, 2'b01, 3, 3'b000, 1'b0, 1'b0};
    vecs[5]  = '{3'b000, 2'b01, 1, 3'b000, 1'b0, 1'b0};
    vecs[6]  = '{3'b000, 2'b01, 1, 3'b000, 1'b0, 1'b0};
    vecs[7]  = '{3'b000, 2'b01, 4, 3'b000, 1'b0, 1'b0};
    // OR mode, 010 held
    vecs[8]  = '{3'b010, 2'b01, 5, 3'b000, 1'b0, 1'b0};
    vecs[9]  = '{3'b010, 2'b01, 1, 3'b010, 1'b0, 1'b0};
    vecs[10] = '{3'b010, 2'b01, 1, 3'b010, 1'b1, 1'b1};
    vecs[11] = '{3'b010, 2'b01, 1, 3'b010, 1'b1, 1'b0};
    // Reach db=110 then sweep modes
    vecs[12] = '{3'b110, 2'b01, 6, 3'b110, 1'b1, 1'b0};
    vecs[13] = '{3'b110, 2'b01, 1, 3'b110, 1'b1, 1'b0};
    vecs[14] = '{3'b110, 2'b00, 1, 3'b110, 1'b0, 1'b1};
    vecs[15] = '{3'b110, 2'b01, 1, 3'b110, 1'b1, 1'b1};
    vecs[16] = '{3'b110, 2'b10, 1, 3'b110, 1'b0, 1'b1};
    vecs[17] = '{3'b110, 2'b11, 1, 3'b110, 1'b1, 1'b1};
    vecs[18] = '{3'b110, 2'b11, 1, 3'b110, 1'b1, 1'b0};
    vecs[19] = '{3'b110, 2'b01, 1, 3'b110, 1'b1, 1'b0};
    // Back to 000 in AND mode, then all three channels rise together
    vecs[20] = '{3'b000, 2'b00, 6, 3'b000, 1'b0, 1'b0};
    vecs[21] = '{3'b000, 2'b00, 1, 3'b000, 1'b0, 1'b0};
    vecs[22] = '{3'b111, 2'b00, 6, 3'b111, 1'b0, 1'b0};
    vecs[23] = '{3'b111, 2'b00, 1, 3'b111, 1'b1, 1'b1};
    vecs[24] = '{3'b111, 2'b00, 1, 3'b111, 1'b1, 1'b0};

    // Reset with all buttons pressed
    rst    = 1'b1;
    btn_in = 3'b111;
    mode   = 2'b00;
    #1;
    check_all("reset_async", 1'b0, 3'b000, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check_all("reset_held", 1'b0, 3'b000, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_all("release_e1", 1'b1, 3'b000, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check_all("release_e5", 1'b1, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    check_all("release_e6", 1'b1, 3'b111, 1'b0, 1'b0);
    @(negedge clk);
    check_all("release_e7", 1'b1, 3'b111, 1'b1, 1'b1);
    @(negedge clk);
    check_all("release_e8", 1'b1, 3'b111, 1'b1, 1'b0);

    for (int v = 0; v < 25; v++) begin
      btn_in = vecs[v].btn;
      mode   = vecs[v].mode;
      repeat (vecs[v].cycles) @(negedge clk);
      check_all($sformatf("vec%0d", v), 1'b1, vecs[v].led, vecs[v].res, vecs[v].chg);
    end

    // Reset arriving while channel 1 is halfway through debouncing a release
    btn_in = 3'b101;
    repeat (4) @(negedge clk);
    check_all("middb_pre", 1'b1, 3'b111, 1'b1, 1'b0);
    rst    = 1'b1;
    btn_in = 3'b111;
    #1;
    check_all("middb_async", 1'b0, 3'b000, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all("middb_e1", 1'b1, 3'b000, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check_all("middb_e5", 1'b1, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    check_all("middb_e6", 1'b1, 3'b111, 1'b0, 1'b0);
    @(negedge clk);
    check_all("middb_e7", 1'b1, 3'b111, 1'b1, 1'b1);
    @(negedge clk);
    check_all("middb_e8", 1'b1, 3'b111, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
